// File: rtl/video_pkg.sv
// Shared timing constants, bar colour table and pattern encoding for the video timing generator.
// Defaults describe 1280x720 with 1650x750 totals.
package video_pkg;

  localparam int VID_H_ACTIVE = 1280;
  localparam int VID_H_FP     = 110;
  localparam int VID_H_SYNC   = 40;
  localparam int VID_H_BP     = 220;
  localparam int VID_V_ACTIVE = 720;
  localparam int VID_V_FP     = 5;
  localparam int VID_V_SYNC   = 5;
  localparam int VID_V_BP     = 20;
  localparam bit VID_H_POL    = 1'b1;
  localparam bit VID_V_POL    = 1'b1;

  // Wide enough for both 1650 and 750 totals, and for the ramp/grid bit picks.
  localparam int CNT_W = 12;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_RAMP  = 2'd1,
    PAT_GRID  = 2'd2,
    PAT_SOLID = 2'd3
  } pat_e;

  // Index 0 is the leftmost bar.
  localparam logic [7:0][23:0] BAR_COLOUR = {
    24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
    24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
  };

endpackage

// File: rtl/video_timing_ctr.sv
// Horizontal/vertical raster counters with blank, sync and data-enable decode of the
// current position; the decode is combinational and registered by the parent.
module video_timing_ctr
  import video_pkg::*;
#(
  parameter int H_ACTIVE = VID_H_ACTIVE,
  parameter int H_FP     = VID_H_FP,
  parameter int H_SYNC   = VID_H_SYNC,
  parameter int H_BP     = VID_H_BP,
  parameter int V_ACTIVE = VID_V_ACTIVE,
  parameter int V_FP     = VID_V_FP,
  parameter int V_SYNC   = VID_V_SYNC,
  parameter int V_BP     = VID_V_BP,
  parameter bit H_POL    = VID_H_POL,
  parameter bit V_POL    = VID_V_POL
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cen_i,
  output logic [CNT_W-1:0] h_cnt_o,
  output logic [CNT_W-1:0] v_cnt_o,
  output logic             hblank_o,
  output logic             vblank_o,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             de_o
);

  localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;

  always_comb begin
    h_cnt_d = h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else if (cen_i) begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Vsync decodes only v_cnt, so it switches on whole-line boundaries.
  always_comb begin
    hblank_o = (h_cnt_q >= H_ACT_END);
    vblank_o = (v_cnt_q >= V_ACT_END);
    de_o     = ~hblank_o & ~vblank_o;
    hsync_o  = ((h_cnt_q >= H_SYNC_BEG) && (h_cnt_q < H_SYNC_END)) ? H_POL : ~H_POL;
    vsync_o  = ((v_cnt_q >= V_SYNC_BEG) && (v_cnt_q < V_SYNC_END)) ? V_POL : ~V_POL;
  end

  assign h_cnt_o = h_cnt_q;
  assign v_cnt_o = v_cnt_q;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing plus test-pattern source: registered blank/sync/RGB outputs for the
// current pixel, with the pattern choice latched once per frame.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE = VID_H_ACTIVE,
  parameter int H_FP     = VID_H_FP,
  parameter int H_SYNC   = VID_H_SYNC,
  parameter int H_BP     = VID_H_BP,
  parameter int V_ACTIVE = VID_V_ACTIVE,
  parameter int V_FP     = VID_V_FP,
  parameter int V_SYNC   = VID_V_SYNC,
  parameter int V_BP     = VID_V_BP,
  parameter bit H_POL    = VID_H_POL,
  parameter bit V_POL    = VID_V_POL
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cen_i,
  input  logic [1:0]  pat_sel_i,
  input  logic [23:0] solid_rgb_i,
  output logic [1:0]  vh_blank_o,
  output logic [2:0]  dvh_sync_o,
  output logic [23:0] vid_rgb_o,
  output logic        sof_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(BAR_W - 1);

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             hblank, vblank, hsync, vsync, de;

  video_timing_ctr #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .H_POL(H_POL), .V_POL(V_POL)
  ) u_ctr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .cen_i   (cen_i),
    .h_cnt_o (h_cnt),
    .v_cnt_o (v_cnt),
    .hblank_o(hblank),
    .vblank_o(vblank),
    .hsync_o (hsync),
    .vsync_o (vsync),
    .de_o    (de)
  );

  logic             first_px;
  pat_e             pat_q, pat_d;
  logic [CNT_W-1:0] bar_pix_q, bar_pix_d;
  logic [2:0]       bar_idx_q, bar_idx_d;
  logic [23:0]      pix_rgb, rgb_d;
  logic [1:0]       vh_blank_q;
  logic [2:0]       dvh_sync_q;
  logic [23:0]      rgb_q;
  logic             sof_q;

  // Pixel (0,0) already uses the newly selected pattern so no frame mixes two patterns.
  always_comb begin
    first_px = (h_cnt == '0) && (v_cnt == '0);
    pat_d    = first_px ? pat_e'(pat_sel_i) : pat_q;
  end

  // Bar position tracks h_cnt without a divider; bar 7 absorbs any remainder pixels.
  always_comb begin
    bar_pix_d = bar_pix_q + 1'b1;
    bar_idx_d = bar_idx_q;
    if (h_cnt == H_LAST) begin
      bar_pix_d = '0;
      bar_idx_d = '0;
    end else if (bar_pix_q == BAR_LAST) begin
      bar_pix_d = '0;
      bar_idx_d = (bar_idx_q == 3'd7) ? 3'd7 : bar_idx_q + 3'd1;
    end
  end

  always_comb begin
    unique case (pat_d)
      PAT_BARS:  pix_rgb = BAR_COLOUR[bar_idx_q];
      PAT_RAMP:  pix_rgb = {h_cnt[7:0], h_cnt[7:0], h_cnt[7:0]};
      PAT_GRID:  pix_rgb = ((h_cnt[4:0] == 5'd0) || (v_cnt[4:0] == 5'd0)) ? 24'hFFFFFF : 24'h000000;
      PAT_SOLID: pix_rgb = solid_rgb_i;
      default:   pix_rgb = 24'h000000;
    endcase
    rgb_d = de ? pix_rgb : 24'h000000;
  end

  // sof drops on every non-enabled clk so it is exactly one clk wide.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pat_q      <= PAT_BARS;
      bar_pix_q  <= '0;
      bar_idx_q  <= '0;
      vh_blank_q <= 2'b11;
      dvh_sync_q <= {1'b0, ~V_POL, ~H_POL};
      rgb_q      <= '0;
      sof_q      <= 1'b0;
    end else begin
      sof_q <= cen_i & first_px;
      if (cen_i) begin
        pat_q      <= pat_d;
        bar_pix_q  <= bar_pix_d;
        bar_idx_q  <= bar_idx_d;
        vh_blank_q <= {vblank, hblank};
        dvh_sync_q <= {de, vsync, hsync};
        rgb_q      <= rgb_d;
      end
    end
  end

  assign vh_blank_o = vh_blank_q;
  assign dvh_sync_o = dvh_sync_q;
  assign vid_rgb_o  = rgb_q;
  assign sof_o      = sof_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen with a reduced 24x8 raster: a reference-model
// scoreboard on every clk plus a table of hand-derived pixels and frame-level counts.
module tb_video_timing_gen;

  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 4,  VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst;
  logic        cen;
  logic [1:0]  patSel;
  logic [23:0] solidRgb;
  logic [1:0]  vhBlank;
  logic [2:0]  dvhSync;
  logic [23:0] vidRgb;
  logic        sof;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(1'b1), .V_POL(1'b1)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .cen_i      (cen),
    .pat_sel_i  (patSel),
    .solid_rgb_i(solidRgb),
    .vh_blank_o (vhBlank),
    .dvh_sync_o (dvhSync),
    .vid_rgb_o  (vidRgb),
    .sof_o      (sof)
  );

  // Free-running pixel clock.
  always #5 clk = ~clk;

  // Watchdog so a stuck run still ends with a failure report.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct packed {
    logic [1:0]  vh;
    logic [2:0]  dvh;
    logic [23:0] rgb;
    logic        sof;
  } exp_t;

  typedef struct {
    int          h;
    int          v;
    int          pat;
    logic [1:0]  vh;
    logic [2:0]  dvh;
    logic [23:0] rgb;
  } vec_t;

  vec_t vecs[$];
  exp_t sbQ[$];
  int   tblQ[$];
  int   sofCycles[$];

  int   vectors = 0;
  int   miscompares = 0;
  int   mh, mv, mpat;
  exp_t lastExp;
  int   cycleNo;
  bit   statsOn, sofRec;
  int   deCnt, vsCnt, hbCnt, hsCnt;

  localparam exp_t RESET_EXP = '{vh: 2'b11, dvh: 3'b000, rgb: 24'h0, sof: 1'b0};

  function automatic logic [23:0] barColourOf(input int idx);
    case (idx)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  // Reference model of one emitted pixel at raster position (h,v).
  function automatic exp_t modelPixel(input int h, input int v, input int pat, input logic [23:0] solid);
    exp_t e;
    logic hb, vb, de;
    logic [7:0] h8;
    int idx;
    hb = (h >= HA);
    vb = (v >= VA);
    de = !hb && !vb;
    e.vh  = {vb, hb};
    e.dvh = {de, (v >= VA + VF && v < VA + VF + VS), (h >= HA + HF && h < HA + HF + HS)};
    e.rgb = 24'h0;
    e.sof = 1'b0;
    if (de) begin
      case (pat)
        0: begin
          idx = h / (HA / 8);
          if (idx > 7) idx = 7;
          e.rgb = barColourOf(idx);
        end
        1: begin
          h8 = 8'(h);
          e.rgb = {h8, h8, h8};
        end
        2: e.rgb = ((h % 32 == 0) || (v % 32 == 0)) ? 24'hFFFFFF : 24'h000000;
        default: e.rgb = solid;
      endcase
    end
    return e;
  endfunction

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (model h=%0d v=%0d, cycle %0d)",
               name, act, expv, mh, mv, cycleNo);
    end
  endtask

  task automatic checkReset(input string name);
    compare({name, " vh_blank"}, 32'(vhBlank), 32'(RESET_EXP.vh));
    compare({name, " dvh_sync"}, 32'(dvhSync), 32'(RESET_EXP.dvh));
    compare({name, " rgb"},      32'(vidRgb),  32'(RESET_EXP.rgb));
    compare({name, " sof"},      32'(sof),     32'(RESET_EXP.sof));
  endtask

  task automatic resetModel();
    mh = 0;
    mv = 0;
    mpat = 0;
    lastExp = RESET_EXP;
    sbQ.delete();
    tblQ.delete();
  endtask

  task automatic checkOutput();
    exp_t e;
    int   idx;
    if (sbQ.size() == 0) begin
      compare("scoreboard empty", 32'd1, 32'd0);
    end else begin
      e = sbQ.pop_front();
      compare("sb vh_blank", 32'(vhBlank), 32'(e.vh));
      compare("sb dvh_sync", 32'(dvhSync), 32'(e.dvh));
      compare("sb rgb",      32'(vidRgb),  32'(e.rgb));
      compare("sb sof",      32'(sof),     32'(e.sof));
    end
    while (tblQ.size() > 0) begin
      idx = tblQ.pop_front();
      compare($sformatf("tbl[%0d] vh_blank", idx), 32'(vhBlank), 32'(vecs[idx].vh));
      compare($sformatf("tbl[%0d] dvh_sync", idx), 32'(dvhSync), 32'(vecs[idx].dvh));
      compare($sformatf("tbl[%0d] rgb", idx),      32'(vidRgb),  32'(vecs[idx].rgb));
    end
    if (statsOn) begin
      deCnt += int'(dvhSync[2]);
      vsCnt += int'(dvhSync[1]);
      hsCnt += int'(dvhSync[0]);
      hbCnt += int'(vhBlank[0]);
    end
    if (sofRec && sof) sofCycles.push_back(cycleNo);
  endtask

  // Drive one clk: predict the output, queue it, advance the model, then check after the edge.
  task automatic applyStimulus(input logic c, input logic [1:0] p, input logic [23:0] s);
    exp_t e;
    int   ep;
    cen = c;
    patSel = p;
    solidRgb = s;
    if (c) begin
      ep = (mh == 0 && mv == 0) ? int'(p) : mpat;
      mpat = ep;
      e = modelPixel(mh, mv, ep, s);
      e.sof = (mh == 0 && mv == 0);
      foreach (vecs[i])
        if (vecs[i].h == mh && vecs[i].v == mv && vecs[i].pat == ep) tblQ.push_back(i);
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh++;
      end
    end else begin
      e = lastExp;
      e.sof = 1'b0;
    end
    lastExp = e;
    sbQ.push_back(e);
    @(posedge clk);
    #1;
    cycleNo++;
    checkOutput();
  endtask

  initial begin
    rst = 1'b1;
    cen = 1'b0;
    patSel = 2'd0;
    solidRgb = 24'h0;
    cycleNo = 0;
    statsOn = 0;
    sofRec = 0;
    deCnt = 0; vsCnt = 0; hbCnt = 0; hsCnt = 0;

    // {h, v, effective pattern, vh_blank, dvh_sync, rgb}, all derived by hand.
    vecs.push_back('{0,  0, 0, 2'b00, 3'b100, 24'hFFFFFF});
    vecs.push_back('{2,  0, 0, 2'b00, 3'b100, 24'hFFFF00});
    vecs.push_back('{5,  1, 0, 2'b00, 3'b100, 24'h00FFFF});
    vecs.push_back('{7,  1, 0, 2'b00, 3'b100, 24'h00FF00});
    vecs.push_back('{9,  1, 0, 2'b00, 3'b100, 24'hFF00FF});
    vecs.push_back('{11, 2, 0, 2'b00, 3'b100, 24'hFF0000});
    vecs.push_back('{13, 2, 0, 2'b00, 3'b100, 24'h0000FF});
    vecs.push_back('{15, 3, 0, 2'b00, 3'b100, 24'h000000});
    vecs.push_back('{16, 0, 0, 2'b01, 3'b000, 24'h000000});
    vecs.push_back('{17, 1, 0, 2'b01, 3'b000, 24'h000000});
    vecs.push_back('{18, 0, 0, 2'b01, 3'b001, 24'h000000});
    vecs.push_back('{20, 0, 0, 2'b01, 3'b001, 24'h000000});
    vecs.push_back('{21, 0, 0, 2'b01, 3'b000, 24'h000000});
    vecs.push_back('{0,  4, 0, 2'b10, 3'b000, 24'h000000});
    vecs.push_back('{0,  5, 0, 2'b10, 3'b010, 24'h000000});
    vecs.push_back('{19, 6, 0, 2'b11, 3'b011, 24'h000000});
    vecs.push_back('{23, 7, 0, 2'b11, 3'b000, 24'h000000});
    vecs.push_back('{5,  0, 1, 2'b00, 3'b100, 24'h050505});
    vecs.push_back('{15, 3, 1, 2'b00, 3'b100, 24'h0F0F0F});
    vecs.push_back('{0,  1, 2, 2'b00, 3'b100, 24'hFFFFFF});
    vecs.push_back('{3,  0, 2, 2'b00, 3'b100, 24'hFFFFFF});
    vecs.push_back('{3,  2, 2, 2'b00, 3'b100, 24'h000000});
    vecs.push_back('{7,  1, 3, 2'b00, 3'b100, 24'h123456});
    vecs.push_back('{7,  2, 3, 2'b00, 3'b100, 24'hABCDEF});
    vecs.push_back('{17, 2, 3, 2'b01, 3'b000, 24'h000000});

    repeat (3) @(posedge clk);
    #1;
    checkReset("reset state");
    rst = 1'b0;
    resetModel();

    // Frame 0: bars, with a pattern change at line 2 that must wait for the next frame.
    statsOn = 1;
    sofRec = 1;
    for (int i = 0; i < FRAME; i++) applyStimulus(1'b1, (mv >= 2) ? 2'd1 : 2'd0, 24'h123456);
    statsOn = 0;
    compare("D_sync clks per frame", 32'(deCnt), 32'd64);
    compare("Vsync clks per frame",  32'(vsCnt), 32'd48);
    compare("Hsync clks per frame",  32'(hsCnt), 32'd24);
    compare("Hblank clks per frame", 32'(hbCnt), 32'd64);

    // Frame 1: ramp.
    for (int i = 0; i < FRAME; i++) applyStimulus(1'b1, 2'd1, 24'h123456);
    sofRec = 0;
    if (sofCycles.size() < 2) begin
      compare("sof pulses seen", 32'(sofCycles.size()), 32'd2);
    end else begin
      compare("first sof cycle", 32'(sofCycles[0]), 32'd1);
      compare("frame period",    32'(sofCycles[1] - sofCycles[0]), 32'(FRAME));
    end

    // Frame 2: grid, with a mid-frame request for solid that must be ignored.
    for (int i = 0; i < FRAME; i++) applyStimulus(1'b1, (mv >= 3) ? 2'd3 : 2'd2, 24'h123456);

    // Frame 3: solid colour, which follows its input mid-frame.
    for (int i = 0; i < FRAME; i++)
      applyStimulus(1'b1, 2'd3, (mv >= 2) ? 24'hABCDEF : 24'h123456);

    // Clock-enable toggling from a fresh reset: outputs hold, sof stays one clk wide.
    rst = 1'b1;
    #2;
    checkReset("reset before cen toggle");
    @(posedge clk);
    #1;
    rst = 1'b0;
    resetModel();
    for (int i = 0; i < 4 * FRAME; i++) applyStimulus((i % 2) == 0, 2'd0, 24'h123456);

    // Asynchronous reset in the middle of line 2.
    for (int k = 0; k < 2 * FRAME && !(mh == 9 && mv == 2); k++) applyStimulus(1'b1, 2'd0, 24'h123456);
    if (!(mh == 9 && mv == 2)) compare("reach h=9 v=2", 32'(mh * 100 + mv), 32'd902);
    rst = 1'b1;
    #2;
    checkReset("async reset mid-line");
    @(posedge clk);
    #1;
    checkReset("reset held");
    rst = 1'b0;
    resetModel();
    applyStimulus(1'b1, 2'd0, 24'h123456);
    compare("sof after reset release", 32'(sof), 32'd1);
    for (int i = 0; i < 30; i++) applyStimulus(1'b1, 2'd0, 24'h123456);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
